// File: rtl/alu_result_uart_tx_if.sv
// Handshake bundle between the control FSM and the ALU-result UART transmitter.
interface alu_result_uart_tx_if #(
    parameter int LENGTH = 32
);
    logic              start;
    logic [LENGTH-1:0] data_in;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (output start, output data_in, input tx, input busy, input done);
    modport slave  (input start, input data_in, output tx, output busy, output done);
endinterface

// File: rtl/alu_result_uart_tx.sv
// Serialises a LENGTH-bit ALU result as LENGTH/8 UART frames, LSB byte first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module alu_result_uart_tx #(
    parameter int LENGTH       = 32,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_result_uart_tx_if.slave  bus
);
    // state  | meaning
    // IDLE   | line high, waiting for start
    // START  | start bit (tx=0)
    // DATA   | 8 data bits, LSB first
    // PARITY | even parity bit (parity build only)
    // STOP   | stop bit (tx=1), then next byte or IDLE
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    localparam int BYTES  = LENGTH / 8;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [2:0]        r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_cnt;
    logic [BYTE_W-1:0] r_byte_cnt;
    logic [LENGTH-1:0] r_shift;
    logic              r_done;
`ifdef UART_TX_PARITY_EN
    logic              r_parity;
`endif
    logic              w_bit_end;
    logic              w_last_byte;
    logic              w_tx;

    assign w_bit_end   = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_last_byte = (r_byte_cnt == BYTE_W'(BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_shift    <= bus.data_in;
                        r_byte_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_baud     <= '0;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
`ifdef UART_TX_PARITY_EN
                        r_parity <= 1'b0;
`endif
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        // Shifting out each bit leaves the next byte aligned at [7:0].
                        r_shift <= r_shift >> 1;
`ifdef UART_TX_PARITY_EN
                        r_parity <= r_parity ^ r_shift[0];
`endif
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            r_state   <= PARITY;
`else
                            r_state   <= STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (w_last_byte) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            r_state    <= START;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            START:  w_tx = 1'b0;
            DATA:   w_tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY: w_tx = r_parity;
`endif
            default: w_tx = 1'b1;
        endcase
    end

    assign bus.tx   = w_tx;
    assign bus.busy = (r_state != IDLE);
    assign bus.done = r_done;
endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Directed bench for alu_result_uart_tx with CLKS_PER_BIT=4, LENGTH=32.
module tb_alu_result_uart_tx;
    localparam int LEN = 32;
    localparam int CPB = 4;
    localparam int NB  = LEN / 8;
`ifdef UART_TX_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic samp [0:1023];
    int   n_samp;

    alu_result_uart_tx_if #(.LENGTH(LEN)) bus ();
    alu_result_uart_tx #(.LENGTH(LEN), .CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] decode_byte(input int b);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = samp[(b * F + 1 + i) * CPB + CPB / 2];
        return v;
    endfunction

    // Records tx for every busy cycle; returns at the first negedge with busy low.
    task automatic capture(input int inj, input logic [31:0] inj_data,
                           output int busy_cyc, output logic done_end);
        busy_cyc = 0;
        done_end = 1'b0;
        n_samp   = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (c == 0) bus.start = 1'b0;
            if (c == inj) begin
                bus.start   = 1'b1;
                bus.data_in = inj_data;
            end
            if (c == inj + 1) bus.start = 1'b0;
            if (!bus.busy) begin
                done_end = bus.done;
                return;
            end
            samp[n_samp] = bus.tx;
            n_samp++;
            busy_cyc++;
        end
        n_tests++;
        n_fail++;
        $display("FAIL capture_timeout: busy still 1 after 1000 cycles, required 0");
    endtask

    task automatic issue_start(input logic [31:0] d);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = d;
    endtask

    task automatic test_reset();
        logic bad;
        bus.start   = 1'b0;
        bus.data_in = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.tx, bus.busy, bus.done} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_in: tx/busy/done=%b required 100", {bus.tx, bus.busy, bus.done});
        end
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if ({bus.tx, bus.busy, bus.done} !== 3'b100) bad = 1'b1;
        end
        n_tests++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: activity seen without start=%b required 0", bad);
        end
    endtask

    task automatic test_single();
        int   bc;
        logic de;
        logic [7:0] exp_b [0:3];
        logic [9:0] frame;
        logic [7:0] got;
        exp_b = '{8'h78, 8'h56, 8'h34, 8'h12};
        frame = 10'b1_0111_1000_0;   // bit k of frame = k-th tx bit
        issue_start(32'h12345678);
        capture(-5, 32'h0, bc, de);
        n_tests++;
        if (bc !== NB * F * CPB) begin
            n_fail++;
            $display("FAIL single_busy_len: got %0d cycles required %0d", bc, NB * F * CPB);
        end
        n_tests++;
        if (de !== 1'b1) begin
            n_fail++;
            $display("FAIL single_done: got %b required 1", de);
        end
        for (int b = 0; b < 4; b++) begin
            got = decode_byte(b);
            n_tests++;
            if (got !== exp_b[b]) begin
                n_fail++;
                $display("FAIL single_byte%0d: got %h required %h", b, got, exp_b[b]);
            end
        end
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if ({samp[(k + 1) * CPB], samp[(k + 1) * CPB + 1], samp[(k + 1) * CPB + 2], samp[(k + 1) * CPB + 3]}
                !== {4{frame[k + 1]}}) begin
                n_fail++;
                $display("FAIL single_frame_bit%0d: got %b%b%b%b required %b x4", k + 1,
                         samp[(k + 1) * CPB], samp[(k + 1) * CPB + 1], samp[(k + 1) * CPB + 2],
                         samp[(k + 1) * CPB + 3], frame[k + 1]);
            end
        end
        n_tests++;
        if ({samp[0], samp[1], samp[2], samp[3]} !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_start_bit: got %b%b%b%b required 0000", samp[0], samp[1], samp[2], samp[3]);
        end
        n_tests++;
        if (samp[(F - 1) * CPB + 2] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_stop_bit: got %b required 1", samp[(F - 1) * CPB + 2]);
        end
        @(negedge clk);
        n_tests++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done_width: done=%b one cycle later, required 0", bus.done);
        end
    endtask

    task automatic test_start_during_busy();
        int   bc;
        logic de;
        logic [7:0] got;
        logic [7:0] exp_b [0:3];
        exp_b = '{8'h01, 8'h00, 8'h00, 8'h00};
        issue_start(32'h00000001);
        capture(49, 32'hFFFFFFFF, bc, de);
        for (int b = 0; b < 4; b++) begin
            got = decode_byte(b);
            n_tests++;
            if (got !== exp_b[b]) begin
                n_fail++;
                $display("FAIL busy_ignore_byte%0d: got %h required %h", b, got, exp_b[b]);
            end
        end
        n_tests++;
        if (bc !== NB * F * CPB || de !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_ignore_len: got %0d cycles done=%b required %0d done=1", bc, de, NB * F * CPB);
        end
        @(negedge clk);
        n_tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ignore_single_done: done=%b busy=%b required 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int   bc;
        logic de;
        logic [7:0] got;
        issue_start(32'h11223344);
        capture(-5, 32'h0, bc, de);
        n_tests++;
        if (de !== 1'b1 || bus.tx !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done_cycle: done=%b tx=%b required 1 1", de, bus.tx);
        end
        bus.start   = 1'b1;
        bus.data_in = 32'hA5A5A5A5;
        capture(-5, 32'h0, bc, de);
        n_tests++;
        if (samp[0] !== 1'b0 || bc !== NB * F * CPB) begin
            n_fail++;
            $display("FAIL b2b_restart: first tx=%b busy=%0d required 0 and %0d", samp[0], bc, NB * F * CPB);
        end
        for (int b = 0; b < 4; b++) begin
            got = decode_byte(b);
            n_tests++;
            if (got !== 8'hA5) begin
                n_fail++;
                $display("FAIL b2b_byte%0d: got %h required a5", b, got);
            end
        end
    endtask

    task automatic test_async_reset();
        int   bc;
        logic de;
        logic seen_done;
        logic [7:0] got;
        logic [7:0] exp_b [0:3];
        exp_b = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        issue_start(32'hDEADBEEF);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (58) @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre_busy: got %b required 1", bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_immediate: tx=%b busy=%b required 1 0", bus.tx, bus.busy);
        end
        seen_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen_done = 1'b1;
        end
        n_tests++;
        if (seen_done !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_no_done: done seen=%b required 0", seen_done);
        end
        issue_start(32'hCAFEF00D);
        capture(-5, 32'h0, bc, de);
        n_tests++;
        if (bc !== NB * F * CPB || de !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_fresh_len: got %0d done=%b required %0d done=1", bc, de, NB * F * CPB);
        end
        for (int b = 0; b < 4; b++) begin
            got = decode_byte(b);
            n_tests++;
            if (got !== exp_b[b]) begin
                n_fail++;
                $display("FAIL arst_fresh_byte%0d: got %h required %h", b, got, exp_b[b]);
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int   bc;
        logic de;
        logic [3:0] par;
        issue_start(32'h00000007);
        capture(-5, 32'h0, bc, de);
        n_tests++;
        if (bc !== 176) begin
            n_fail++;
            $display("FAIL parity_busy_len: got %0d required 176", bc);
        end
        for (int b = 0; b < 4; b++) par[b] = samp[(b * F + 9) * CPB + 2];
        n_tests++;
        if (par !== 4'b0001) begin
            n_fail++;
            $display("FAIL parity_bits: got %b required 0001", par);
        end
        n_tests++;
        if (decode_byte(0) !== 8'h07) begin
            n_fail++;
            $display("FAIL parity_byte0: got %h required 07", decode_byte(0));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_start_during_busy();
        test_back_to_back();
        test_async_reset();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
